// File: rtl/store_aligner.sv
// rtl/store_aligner.sv - store width decode, lane alignment, beat split and memory write handshake
module store_aligner #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic        amo_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        busy,
    output logic        done,
    output logic        fault_misaligned,
    output logic        fault_illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_FIN
    } state_t;

    state_t      state_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_mis_q;
    logic        fault_ill_q;

    // Second beat is computed at request time and parked here until the first beat is accepted.
    logic [31:0] hi_addr_q;
    logic [31:0] hi_wdata_q;
    logic [3:0]  hi_wstrb_q;
    logic        has_hi_q;

    logic [3:0]  req_mask;
    logic        req_illegal;
    logic [1:0]  req_off;
    logic [31:0] req_byte_en;
    logic [7:0]  req_strb;
    logic [63:0] req_data;
    logic        req_has_hi;
    logic        req_misaligned;
    logic [31:0] req_word_addr;
    logic [31:0] req_hi_addr;

    // Decode the live request inputs; only consumed on the cycle start is accepted in IDLE.
    always_comb begin
        req_illegal = 1'b0;
        req_mask    = 4'b1111;
        if (!amo_store) begin
            case (funct3)
                3'b000:  req_mask = 4'b0001;
                3'b001:  req_mask = 4'b0011;
                3'b010:  req_mask = 4'b1111;
                default: begin
                    req_mask    = 4'b0000;
                    req_illegal = 1'b1;
                end
            endcase
        end
        req_off     = addr[1:0];
        req_byte_en = {{8{req_mask[3]}}, {8{req_mask[2]}}, {8{req_mask[1]}}, {8{req_mask[0]}}};
        // Bytes above the store width are cleared before shifting so unstrobed lanes read as zero.
        req_strb    = {4'b0000, req_mask} << req_off;
        req_data    = {32'h0000_0000, wdata & req_byte_en} << {req_off, 3'b000};
        req_has_hi  = |req_strb[7:4];
        // AMO write-backs must be naturally aligned whether or not splitting is enabled.
        if (amo_store) begin
            req_misaligned = (req_off != 2'b00);
        end else begin
            req_misaligned = req_has_hi && !ALLOW_MISALIGNED;
        end
        req_word_addr = {addr[31:2], 2'b00};
        req_hi_addr   = req_word_addr + 32'd4;
    end

    // Control FSM with all bus and status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_mis_q <= 1'b0;
            fault_ill_q <= 1'b0;
            hi_addr_q   <= 32'h0000_0000;
            hi_wdata_q  <= 32'h0000_0000;
            hi_wstrb_q  <= 4'b0000;
            has_hi_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (req_illegal) begin
                            fault_ill_q <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= S_FIN;
                        end else if (req_misaligned) begin
                            fault_mis_q <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= S_FIN;
                        end else begin
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= req_word_addr;
                            mem_wdata_q <= req_data[31:0];
                            mem_wstrb_q <= req_strb[3:0];
                            hi_addr_q   <= req_hi_addr;
                            hi_wdata_q  <= req_data[63:32];
                            hi_wstrb_q  <= req_strb[7:4];
                            has_hi_q    <= req_has_hi;
                            state_q     <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (mem_ready) begin
                        if (has_hi_q) begin
                            mem_addr_q  <= hi_addr_q;
                            mem_wdata_q <= hi_wdata_q;
                            mem_wstrb_q <= hi_wstrb_q;
                            state_q     <= S_HI;
                        end else begin
                            mem_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_FIN;
                        end
                    end
                end
                S_HI: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q      <= 1'b0;
                    fault_mis_q <= 1'b0;
                    fault_ill_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_valid        = mem_valid_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_wstrb        = mem_wstrb_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign fault_misaligned = fault_mis_q;
    assign fault_illegal    = fault_ill_q;

endmodule

// File: tb/tb_store_aligner.sv
// tb/tb_store_aligner.sv - randomized model-checked bench for store_aligner (split and no-split variants)
module tb_store_aligner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic        amo_store;
    logic [31:0] addr;
    logic [31:0] wdata;

    // Index 0: ALLOW_MISALIGNED = 1, index 1: ALLOW_MISALIGNED = 0
    logic        mem_ready [2];
    logic        mem_valid [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];
    logic        busy      [2];
    logic        done      [2];
    logic        fmis      [2];
    logic        fill      [2];

    store_aligner #(.ALLOW_MISALIGNED(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3), .amo_store(amo_store),
        .addr(addr), .wdata(wdata), .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
        .busy(busy[0]), .done(done[0]), .fault_misaligned(fmis[0]), .fault_illegal(fill[0])
    );

    store_aligner #(.ALLOW_MISALIGNED(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3), .amo_store(amo_store),
        .addr(addr), .wdata(wdata), .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
        .busy(busy[1]), .done(done[1]), .fault_misaligned(fmis[1]), .fault_illegal(fill[1])
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected outcome of the current request, one set per instance
    int          exp_n    [2];
    logic [31:0] exp_addr [2][2];
    logic [31:0] exp_data [2][2];
    logic [3:0]  exp_strb [2][2];
    bit          exp_fill [2];
    bit          exp_fmis [2];
    int          req_id = 0;

    int cmp_id [2];
    int beat_i [2];
    bit post_rst;
    int wc [2];
    bit seen [2];
    int lat [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Byte-by-byte reference: each stored byte lands at (addr+i) mod 2^32, grouped by the word it hits.
    task automatic model(input logic [2:0] f3, input bit amo, input logic [31:0] a, input logic [31:0] wd,
                         input bit allow, output int nb, output logic [31:0] a0, output logic [31:0] a1,
                         output logic [31:0] d0, output logic [31:0] d1, output logic [3:0] s0,
                         output logic [3:0] s1, output bit fi, output bit fm);
        int n;
        int lane;
        bit crosses;
        logic [31:0] base;
        logic [31:0] ba;
        n = amo ? 4 : (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        fi = !amo && (f3 > 3'd2);
        crosses = (int'(a[1:0]) + n) > 4;
        fm = !fi && (amo ? (a[1:0] != 2'b00) : (crosses && !allow));
        nb = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; s0 = '0; s1 = '0;
        if (!fi && !fm) begin
            base = a & 32'hFFFF_FFFC;
            a0 = base;
            nb = crosses ? 2 : 1;
            if (crosses) a1 = base + 32'd4;
            for (int i = 0; i < n; i++) begin
                ba = a + i;
                lane = int'(ba[1:0]);
                if ((ba & 32'hFFFF_FFFC) == base) begin
                    d0[8*lane +: 8] = wd[8*i +: 8];
                    s0[lane] = 1'b1;
                end else begin
                    d1[8*lane +: 8] = wd[8*i +: 8];
                    s1[lane] = 1'b1;
                end
            end
        end
    endtask

    // mode 0: ready tied high, 1: random ready, 2: two stall cycles per beat
    task automatic run_req(input logic [2:0] f3, input bit amo, input logic [31:0] a, input logic [31:0] wd,
                           input int mode, input bit poke);
        int c0;
        int k;
        for (int d = 0; d < 2; d++) begin
            model(f3, amo, a, wd, d == 0, exp_n[d], exp_addr[d][0], exp_addr[d][1], exp_data[d][0],
                  exp_data[d][1], exp_strb[d][0], exp_strb[d][1], exp_fill[d], exp_fmis[d]);
            mem_ready[d] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            wc[d] = 0; seen[d] = 0; lat[d] = 0;
        end
        funct3 = f3; amo_store = amo; addr = a; wdata = wd; start = 1'b1;
        c0 = cyc;
        @(posedge clk); #1;
        req_id++;
        funct3 = 3'($urandom); amo_store = 1'($urandom); addr = $urandom; wdata = $urandom;
        k = 0;
        forever begin
            start = 1'b0;
            for (int d = 0; d < 2; d++) begin
                if (done[d] === 1'b1 && !seen[d]) begin
                    seen[d] = 1;
                    lat[d] = cyc - c0;
                end
            end
            if ((seen[0] && seen[1]) || k == 40) break;
            for (int d = 0; d < 2; d++) begin
                if (mode == 1) mem_ready[d] = 1'($urandom_range(0, 1));
                else if (mode == 2) begin
                    if (mem_valid[d] === 1'b1 && wc[d] < 2) begin
                        mem_ready[d] = 1'b0; wc[d]++;
                    end else if (mem_valid[d] === 1'b1) begin
                        mem_ready[d] = 1'b1; wc[d] = 0;
                    end else mem_ready[d] = 1'b0;
                end
            end
            if (poke && k == 1 && !seen[0] && !seen[1]) start = 1'b1;
            k++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("complete_%0d", d), 32'(seen[d]), 32'd1);
            if (mode == 0)
                chk($sformatf("latency_%0d", d), lat[d],
                    (exp_fill[d] || exp_fmis[d]) ? 32'd1 : 32'(exp_n[d] + 1));
        end
        @(posedge clk); #1;
    endtask

    task automatic pin_model();
        int nb; logic [31:0] a0, a1, d0, d1; logic [3:0] s0, s1; bit fi, fm;
        model(3'd2, 0, 32'h1000, 32'hDEADBEEF, 1, nb, a0, a1, d0, d1, s0, s1, fi, fm);
        chk("pin_sw_n", nb, 1); chk("pin_sw_a", a0, 32'h1000);
        chk("pin_sw_s", s0, 4'b1111); chk("pin_sw_d", d0, 32'hDEADBEEF);
        model(3'd0, 0, 32'h2003, 32'h000000A5, 1, nb, a0, a1, d0, d1, s0, s1, fi, fm);
        chk("pin_sb_a", a0, 32'h2000); chk("pin_sb_s", s0, 4'b1000); chk("pin_sb_d", d0, 32'hA5000000);
        model(3'd1, 0, 32'h3003, 32'h00001234, 1, nb, a0, a1, d0, d1, s0, s1, fi, fm);
        chk("pin_sh_n", nb, 2); chk("pin_sh_d0", d0, 32'h34000000); chk("pin_sh_s0", s0, 4'b1000);
        chk("pin_sh_a1", a1, 32'h3004); chk("pin_sh_d1", d1, 32'h00000012); chk("pin_sh_s1", s1, 4'b0001);
        model(3'd2, 0, 32'hFFFFFFFE, 32'h11223344, 1, nb, a0, a1, d0, d1, s0, s1, fi, fm);
        chk("pin_wrap_a0", a0, 32'hFFFFFFFC); chk("pin_wrap_s0", s0, 4'b1100); chk("pin_wrap_d0", d0, 32'h33440000);
        chk("pin_wrap_a1", a1, 32'h0); chk("pin_wrap_s1", s1, 4'b0011); chk("pin_wrap_d1", d1, 32'h00001122);
        model(3'd3, 0, 32'h5000, 32'h0, 1, nb, a0, a1, d0, d1, s0, s1, fi, fm);
        chk("pin_ill", {fi, fm}, 2'b10);
        model(3'd5, 1, 32'h4002, 32'h0, 1, nb, a0, a1, d0, d1, s0, s1, fi, fm);
        chk("pin_amo", {fi, fm}, 2'b01);
        model(3'd2, 0, 32'h4001, 32'h0, 0, nb, a0, a1, d0, d1, s0, s1, fi, fm);
        chk("pin_nosplit", {fi, fm}, 2'b01);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; funct3 = 3'd0; amo_store = 1'b0; addr = '0; wdata = '0;
        mem_ready[0] = 1'b0; mem_ready[1] = 1'b0;
        cmp_id[0] = 0; cmp_id[1] = 0; beat_i[0] = 0; beat_i[1] = 0; post_rst = 1;
        fork
            begin : drive
                repeat (3) @(posedge clk);
                #1 reset = 1'b0;
                @(posedge clk); #1;
                pin_model();
                run_req(3'd2, 0, 32'h1000, 32'hDEADBEEF, 0, 0);
                run_req(3'd0, 0, 32'h2003, 32'h000000A5, 0, 0);
                run_req(3'd1, 0, 32'h3003, 32'h00001234, 2, 0);
                run_req(3'd2, 0, 32'hFFFFFFFE, 32'h11223344, 0, 0);
                run_req(3'd3, 0, 32'h5000, 32'h12345678, 0, 0);
                run_req(3'd0, 1, 32'h4002, 32'hCAFEF00D, 0, 0);
                run_req(3'd2, 0, 32'h4001, 32'h55667788, 0, 0);
                run_req(3'd2, 0, 32'h6002, 32'hA1B2C3D4, 2, 1);
                // Reset while the second beat is stalled
                run_req(3'd0, 0, 32'h10, 32'h1, 0, 0);
                exp_n[0] = 2; exp_addr[0][0] = 32'h5000; exp_data[0][0] = 32'h33440000; exp_strb[0][0] = 4'b1100;
                exp_addr[0][1] = 32'h5004; exp_data[0][1] = 32'h00001122; exp_strb[0][1] = 4'b0011;
                exp_fill[0] = 0; exp_fmis[0] = 0;
                exp_n[1] = 0; exp_fill[1] = 0; exp_fmis[1] = 1;
                funct3 = 3'd2; amo_store = 0; addr = 32'h5002; wdata = 32'h11223344; start = 1'b1;
                mem_ready[0] = 1'b1; mem_ready[1] = 1'b1;
                @(posedge clk); #1; start = 1'b0; req_id++;
                @(posedge clk); #1; mem_ready[0] = 1'b0;
                @(posedge clk); #1;
                chk("hi_before_reset_addr", mem_addr[0], 32'h5004);
                reset = 1'b1;
                @(posedge clk); #1; reset = 1'b0;
                chk("after_reset_valid", 32'(mem_valid[0]), 32'd0);
                chk("after_reset_busy", 32'(busy[0]), 32'd0);
                run_req(3'd2, 0, 32'h7000, 32'h0BADF00D, 0, 0);
                for (int r = 0; r < 150; r++) begin
                    logic [2:0] f3;
                    logic [31:0] a;
                    f3 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
                    a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3))) : $urandom;
                    run_req(f3, $urandom_range(0, 5) == 0, a, $urandom, $urandom_range(0, 2),
                            $urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin : compare
                @(posedge clk);
                forever begin
                    @(negedge clk);
                    for (int d = 0; d < 2; d++) begin
                        if (post_rst) begin
                            chk("rst_valid", 32'(mem_valid[d]), 0); chk("rst_addr", mem_addr[d], 0);
                            chk("rst_wdata", mem_wdata[d], 0); chk("rst_wstrb", 32'(mem_wstrb[d]), 0);
                            chk("rst_busy", 32'(busy[d]), 0); chk("rst_done", 32'(done[d]), 0);
                            chk("rst_faults", {fmis[d], fill[d]}, 0);
                        end else begin
                            chk($sformatf("busy_%0d", d), 32'(busy[d]), 32'(req_id != cmp_id[d]));
                            if (mem_valid[d] !== 1'b0) begin
                                if (req_id != cmp_id[d] && beat_i[d] < exp_n[d]) begin
                                    chk($sformatf("addr_%0d_b%0d", d, beat_i[d]), mem_addr[d], exp_addr[d][beat_i[d]]);
                                    chk($sformatf("wdata_%0d_b%0d", d, beat_i[d]), mem_wdata[d], exp_data[d][beat_i[d]]);
                                    chk($sformatf("wstrb_%0d_b%0d", d, beat_i[d]), 32'(mem_wstrb[d]), 32'(exp_strb[d][beat_i[d]]));
                                    if (mem_ready[d]) beat_i[d]++;
                                end else chk($sformatf("spurious_valid_%0d", d), 32'(mem_valid[d]), 0);
                            end
                            if (done[d] === 1'b1) begin
                                chk($sformatf("done_active_%0d", d), 32'(req_id != cmp_id[d]), 1);
                                chk($sformatf("beats_%0d", d), beat_i[d], exp_n[d]);
                                chk($sformatf("fault_ill_%0d", d), 32'(fill[d]), 32'(exp_fill[d]));
                                chk($sformatf("fault_mis_%0d", d), 32'(fmis[d]), 32'(exp_fmis[d]));
                                cmp_id[d] = req_id;
                                beat_i[d] = 0;
                            end else begin
                                chk($sformatf("faults_idle_%0d", d), {fmis[d], fill[d]}, 0);
                            end
                        end
                    end
                    post_rst = reset;
                    if (reset) begin
                        for (int d = 0; d < 2; d++) begin
                            cmp_id[d] = req_id;
                            beat_i[d] = 0;
                        end
                    end
                end
            end
        join_any
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
